// File: rtl/tx_lane_scheduler_pkg.sv
// Shared types, encodings and symbol defaults for the 4-lane TX scheduler.
// Lane n always maps to byte n of a slot, so lane masks and buffer masks share one helper.
package tx_lane_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } sched_state_e;

    typedef enum logic [1:0] {
        CFG_X1     = 2'd0,
        CFG_X2     = 2'd1,
        CFG_X4     = 2'd2,
        CFG_X4_ALT = 2'd3
    } lane_cfg_e;

    localparam int unsigned NUM_LANES       = 4;
    localparam logic [7:0]  PAD_SYM_DEFAULT = 8'h7C;
    localparam logic [7:0]  SKP_SYM_DEFAULT = 8'h1C;

    function automatic logic [2:0] cfg_width(input logic [1:0] cfg);
        case (lane_cfg_e'(cfg))
            CFG_X1:  return 3'd1;
            CFG_X2:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Thermometer mask with the low n bits set (n = 0..4).
    function automatic logic [NUM_LANES-1:0] count_mask(input logic [2:0] n);
        case (n)
            3'd0:    return 4'b0000;
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            3'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/tx_lane_scheduler_timer.sv
// Slot timer: cycle counter within a symbol slot, boundary flag, and the SKP slot index.
module tx_slot_timer #(
    parameter int unsigned SLOT_CYCLES  = 8,
    parameter int unsigned SKP_INTERVAL = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic active_i,
    input  logic enb_i,
    input  logic in_run_i,
    output logic boundary_o,
    output logic skp_slot_o
);

    localparam int unsigned CW = $clog2(SLOT_CYCLES);
    localparam int unsigned IW = $clog2(SKP_INTERVAL);
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(SKP_INTERVAL - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;

    always_comb begin
        boundary_o = active_i && (cnt_q == CNT_LAST);
        // The ALIGN boundary is always a SKP slot and restarts the index.
        skp_slot_o = boundary_o && (!in_run_i || (idx_q == IDX_LAST));
        cnt_d      = cnt_q + CW'(1);
        idx_d      = idx_q;
        if (!active_i || !enb_i) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (boundary_o) begin
            cnt_d = '0;
            idx_d = skp_slot_o ? '0 : idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/tx_lane_scheduler.sv
// Byte-stream scheduler for the 4-lane TX path: packs accepted bytes into x1/x2/x4
// symbol slots, pads partial slots, inserts periodic SKP slots and strobes the serializers.
module tx_lane_scheduler
    import tx_lane_scheduler_pkg::*;
#(
    parameter int unsigned SLOT_CYCLES  = 8,
    parameter int unsigned SKP_INTERVAL = 16,
    parameter logic [7:0]  PAD_SYM      = PAD_SYM_DEFAULT,
    parameter logic [7:0]  SKP_SYM      = SKP_SYM_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enb,
    input  logic [1:0]  lane_cfg,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] lane_data,
    output logic [3:0]  lane_k,
    output logic        lane_load,
    output logic [3:0]  lane_active,
    output logic        skp_sent
);

    sched_state_e state_q, state_d;

    logic [2:0]                w_q, w_d;
    logic [2:0]                fill_q, fill_d;
    logic [NUM_LANES-1:0][7:0] buf_q, buf_d;
    logic [31:0]               lane_data_q, lane_data_d;
    logic [3:0]                lane_k_q, lane_k_d;
    logic                      lane_load_q, lane_load_d;
    logic                      skp_sent_q, skp_sent_d;

    logic                      active, in_run, boundary, skp_slot;
    logic [NUM_LANES-1:0]      act_mask, fill_mask;

    assign active = (state_q != ST_OFF);
    assign in_run = (state_q == ST_RUN);

    tx_slot_timer #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .SKP_INTERVAL (SKP_INTERVAL)
    ) u_timer (
        .clk_i      (clk),
        .reset_i    (reset),
        .active_i   (active),
        .enb_i      (enb),
        .in_run_i   (in_run),
        .boundary_o (boundary),
        .skp_slot_o (skp_slot)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_OFF;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:   if (enb) state_d = ST_ALIGN;
            ST_ALIGN: begin
                if (!enb)          state_d = ST_OFF;
                else if (boundary) state_d = ST_RUN;
            end
            ST_RUN:   if (!enb) state_d = ST_OFF;
            default:  state_d = ST_OFF;
        endcase
    end

    always_comb begin
        in_ready    = in_run && (fill_q < w_q) && !boundary;
        lane_active = active ? count_mask(w_q) : '0;
    end

    always_comb begin
        fill_d      = fill_q;
        buf_d       = buf_q;
        w_d         = w_q;
        lane_data_d = lane_data_q;
        lane_k_d    = lane_k_q;
        lane_load_d = 1'b0;
        skp_sent_d  = 1'b0;
        act_mask    = count_mask(w_q);
        fill_mask   = count_mask(fill_q);
        if (!active || !enb) begin
            fill_d = '0;
            if (!active && enb) w_d = cfg_width(lane_cfg);
        end else if (boundary) begin
            lane_load_d = 1'b1;
            skp_sent_d  = skp_slot;
            lane_data_d = '0;
            lane_k_d    = '0;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                if (act_mask[i]) begin
                    if (skp_slot) begin
                        lane_data_d[8*i +: 8] = SKP_SYM;
                        lane_k_d[i]           = 1'b1;
                    end else if (fill_mask[i]) begin
                        lane_data_d[8*i +: 8] = buf_q[i];
                    end else begin
                        lane_data_d[8*i +: 8] = PAD_SYM;
                        lane_k_d[i]           = 1'b1;
                    end
                end
            end
            if (!skp_slot) fill_d = '0;
            // Width follows lane_cfg only once the buffer is empty after this slot.
            if (fill_d == '0) w_d = cfg_width(lane_cfg);
        end else if (in_valid && in_ready) begin
            buf_d[fill_q[1:0]] = in_data;
            fill_d             = fill_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_q         <= 3'd1;
            fill_q      <= '0;
            buf_q       <= '0;
            lane_data_q <= '0;
            lane_k_q    <= '0;
            lane_load_q <= 1'b0;
            skp_sent_q  <= 1'b0;
        end else begin
            w_q         <= w_d;
            fill_q      <= fill_d;
            buf_q       <= buf_d;
            lane_data_q <= lane_data_d;
            lane_k_q    <= lane_k_d;
            lane_load_q <= lane_load_d;
            skp_sent_q  <= skp_sent_d;
        end
    end

    assign lane_data = lane_data_q;
    assign lane_k    = lane_k_q;
    assign lane_load = lane_load_q;
    assign skp_sent  = skp_sent_q;

endmodule

// File: tb/tb_tx_lane_scheduler.sv
// Bench for tx_lane_scheduler: queue-based slot model compared every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_tx_lane_scheduler;

    localparam int         SC  = 8;
    localparam int         SKI = 16;
    localparam logic [7:0] PAD = 8'h7C;
    localparam logic [7:0] SKP = 8'h1C;
    localparam int M_OFF = 0, M_ALIGN = 1, M_RUN = 2;

    logic        clk = 1'b0;
    logic        rst_n, enb, in_valid, in_ready, lane_load, skp_sent;
    logic [1:0]  lane_cfg;
    logic [7:0]  in_data;
    logic [31:0] lane_data;
    logic [3:0]  lane_k, lane_active;

    initial forever #5 clk = ~clk;

    tx_lane_scheduler #(
        .SLOT_CYCLES  (SC),
        .SKP_INTERVAL (SKI),
        .PAD_SYM      (PAD),
        .SKP_SYM      (SKP)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .enb         (enb),
        .lane_cfg    (lane_cfg),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .lane_data   (lane_data),
        .lane_k      (lane_k),
        .lane_load   (lane_load),
        .lane_active (lane_active),
        .skp_sent    (skp_sent)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h required %h", name, $time, got, exp);
    endtask

    function automatic int width_of(input logic [1:0] c);
        return (c == 2'd0) ? 1 : ((c == 2'd1) ? 2 : 4);
    endfunction

    function automatic logic [3:0] mask_of(input int n);
        return 4'((1 << n) - 1);
    endfunction

    // Model: state name, cycle-in-slot, slots since last SKP, width and a byte queue for the open slot.
    int          m_state = M_OFF, m_cnt = 0, m_slot = 0, m_w = 1;
    logic [7:0]  m_q[$];
    logic [31:0] m_data = '0;
    logic [3:0]  m_k = '0;
    logic        m_load = 1'b0, m_skp = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_state = M_OFF; m_cnt = 0; m_slot = 0; m_w = 1; m_q.delete();
            m_data = '0; m_k = '0; m_load = 1'b0; m_skp = 1'b0;
        end else begin
            m_load = 1'b0;
            m_skp  = 1'b0;
            if (!enb) begin
                m_state = M_OFF; m_cnt = 0; m_q.delete();
            end else if (m_state == M_OFF) begin
                m_state = M_ALIGN; m_cnt = 0; m_w = width_of(lane_cfg);
            end else if (m_cnt == SC - 1) begin
                m_cnt = 0; m_load = 1'b1; m_data = '0; m_k = '0;
                if (m_state == M_ALIGN || m_slot == SKI - 1) begin
                    for (int i = 0; i < m_w; i++) begin
                        m_data[8*i +: 8] = SKP; m_k[i] = 1'b1;
                    end
                    m_skp = 1'b1; m_slot = 0; m_state = M_RUN;
                end else begin
                    for (int i = 0; i < m_w; i++) begin
                        if (i < m_q.size()) m_data[8*i +: 8] = m_q[i];
                        else begin m_data[8*i +: 8] = PAD; m_k[i] = 1'b1; end
                    end
                    m_q.delete(); m_slot++;
                end
                if (m_q.size() == 0) m_w = width_of(lane_cfg);
            end else begin
                if (m_state == M_RUN && in_valid && m_q.size() < m_w) m_q.push_back(in_data);
                m_cnt++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("lane_data",   lane_data,   m_data);
        check("lane_k",      {28'h0, lane_k}, {28'h0, m_k});
        check("lane_load",   {31'h0, lane_load}, {31'h0, m_load});
        check("skp_sent",    {31'h0, skp_sent},  {31'h0, m_skp});
        check("lane_active", {28'h0, lane_active},
              {28'h0, (m_state == M_OFF) ? 4'h0 : mask_of(m_w)});
        check("in_ready",    {31'h0, in_ready},
              {31'h0, (m_state == M_RUN && m_q.size() < m_w && m_cnt != SC - 1)});
    end

    // Byte source: presents the head of src_q, pops it once a handshake was seen.
    logic [7:0] src_q[$];
    bit         hs;
    initial begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        forever begin
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (hs && src_q.size() > 0) void'(src_q.pop_front());
            in_valid = (src_q.size() > 0);
            in_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
        end
    end

    task automatic wait_load(input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 64 && !seen; c++) begin
            @(negedge clk);
            seen = lane_load;
        end
        n_total++;
        if (seen) n_pass++;
        else $display("FAIL %s: lane_load got 0 required 1 within 64 cycles", name);
    endtask

    task automatic restart(input logic [1:0] cfg);
        enb = 1'b0;
        repeat (2) @(negedge clk);
        src_q.delete();
        lane_cfg = cfg;
        @(negedge clk);
        enb = 1'b1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_data"},   lane_data, 32'h0);
        check({tag, "_k"},      {28'h0, lane_k}, 32'h0);
        check({tag, "_load"},   {31'h0, lane_load}, 32'h0);
        check({tag, "_active"}, {28'h0, lane_active}, 32'h0);
        check({tag, "_skp"},    {31'h0, skp_sent}, 32'h0);
        check({tag, "_ready"},  {31'h0, in_ready}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; enb = 1'b0; lane_cfg = 2'd0;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // x4 back-to-back bytes
        lane_cfg = 2'd2; enb = 1'b1;
        for (int b = 1; b <= 8; b++) src_q.push_back(8'(b));
        wait_load("t1_align");
        check("t1_align_data", lane_data, 32'h1C1C1C1C);
        check("t1_align_k", {28'h0, lane_k}, 32'hF);
        check("t1_align_skp", {31'h0, skp_sent}, 32'h1);
        wait_load("t1_d0");
        check("t1_d0_data", lane_data, 32'h04030201);
        check("t1_d0_k", {28'h0, lane_k}, 32'h0);
        wait_load("t1_d1");
        check("t1_d1_data", lane_data, 32'h08070605);

        // x2, single byte padded
        restart(2'd1);
        src_q.push_back(8'hAA);
        wait_load("t2_align");
        check("t2_align_data", lane_data, 32'h00001C1C);
        wait_load("t2_pad");
        check("t2_pad_data", lane_data, 32'h00007CAA);
        check("t2_pad_k", {28'h0, lane_k}, 32'h2);
        check("t2_active", {28'h0, lane_active}, 32'h3);

        // x1 continuous stream through a SKP interval
        restart(2'd0);
        for (int b = 0; b < 20; b++) src_q.push_back(8'(8'h40 + b));
        wait_load("t3_align");
        for (int i = 0; i < 15; i++) begin
            wait_load("t3_data_load");
            check("t3_data", lane_data, 32'h40 + 32'(i));
            check("t3_data_skp", {31'h0, skp_sent}, 32'h0);
        end
        wait_load("t3_skp");
        check("t3_skp_flag", {31'h0, skp_sent}, 32'h1);
        check("t3_skp_data", lane_data, 32'h0000001C);
        wait_load("t3_after_skp");
        check("t3_after_skp_data", lane_data, 32'h0000004F);

        // x4 -> x1 reconfiguration with two bytes buffered
        restart(2'd2);
        wait_load("t4_align");
        src_q.push_back(8'hB1);
        src_q.push_back(8'hB2);
        lane_cfg = 2'd0;
        wait_load("t4_pad");
        check("t4_pad_data", lane_data, 32'h7C7CB2B1);
        check("t4_pad_k", {28'h0, lane_k}, 32'hC);
        check("t4_active", {28'h0, lane_active}, 32'h1);
        wait_load("t4_x1");
        check("t4_x1_data", lane_data, 32'h0000007C);
        check("t4_x1_k", {28'h0, lane_k}, 32'h1);

        // enb drop mid-slot with three bytes buffered
        restart(2'd2);
        wait_load("t5_align");
        src_q.push_back(8'hC1);
        src_q.push_back(8'hC2);
        src_q.push_back(8'hC3);
        repeat (5) @(negedge clk);
        enb = 1'b0;
        @(negedge clk);
        check("t5_off_load", {31'h0, lane_load}, 32'h0);
        check("t5_off_ready", {31'h0, in_ready}, 32'h0);
        check("t5_off_active", {28'h0, lane_active}, 32'h0);
        check("t5_off_hold_data", lane_data, 32'h1C1C1C1C);
        check("t5_off_hold_k", {28'h0, lane_k}, 32'hF);
        repeat (12) @(negedge clk);
        enb = 1'b1;
        for (int b = 0; b < 4; b++) src_q.push_back(8'(8'hD1 + b));
        wait_load("t5_realign");
        check("t5_realign_skp", {31'h0, skp_sent}, 32'h1);
        check("t5_realign_data", lane_data, 32'h1C1C1C1C);
        wait_load("t5_data");
        check("t5_data", lane_data, 32'hD4D3D2D1);

        // asynchronous reset in the middle of RUN
        for (int b = 0; b < 6; b++) src_q.push_back(8'(8'hE0 + b));
        wait_load("t6_pre");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero_outputs("t6_async");
        src_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_load("t6_align");
        check("t6_align_data", lane_data, 32'h1C1C1C1C);
        check("t6_align_skp", {31'h0, skp_sent}, 32'h1);
        src_q.push_back(8'hF1);
        wait_load("t6_pad");
        check("t6_pad_data", lane_data, 32'h7C7C7CF1);
        check("t6_pad_k", {28'h0, lane_k}, 32'hE);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
